// File: rtl/dac_pattern_player.sv
`default_nettype none
// ============================================================================
//  Module      : dac_pattern_player
//  Description : Sample RAM loaded from a pipe-in stream, played out to the
//                DAC pins at a programmable rate, one-shot or looped.
//  Revision    : 1.0 - initial release
// ============================================================================
module dac_pattern_player #(
    parameter int PRECISION  = 10,
    parameter int ADDR_WIDTH = 10,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_start,
    input  logic                  pipe_write,
    input  logic [15:0]           pipe_data,
    input  logic                  play_start,
    input  logic                  play_stop,
    input  logic                  loop_en,
    input  logic [DIV_WIDTH-1:0]  rate_div,
    output logic [PRECISION-1:0]  dac_code,
    output logic                  dac_update,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   sample_count,
    output logic                  overflow
);

    localparam logic [0:0]          c_IDLE  = 1'b0;
    localparam logic [0:0]          c_PLAY  = 1'b1;
    localparam logic [ADDR_WIDTH:0] c_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [PRECISION-1:0]  r_mem [0:(2**ADDR_WIDTH)-1];
    logic [PRECISION-1:0]  r_ram_q;
    logic [0:0]            r_state;
    logic [PRECISION-1:0]  r_dac_code;
    logic                  r_dac_update;
    logic                  r_done;
    logic                  r_overflow;
    logic [ADDR_WIDTH:0]   r_count;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [DIV_WIDTH-1:0]  r_div;
    logic [DIV_WIDTH-1:0]  r_rate;
    logic                  r_loop;
    logic                  r_last;

    logic                  w_wr_en;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic                  w_is_last;
    logic [ADDR_WIDTH-1:0] w_next_ptr;
    logic                  w_fire;
    logic [ADDR_WIDTH-1:0] w_rd_addr;
    logic                  w_unused_pipe;

    // Only the low PRECISION bits of a pipe word carry a code.
    assign w_unused_pipe = ^pipe_data;

    // Write path, read-address lookahead and sample-advance decode.
    always_comb begin
        w_wr_en    = (r_state == c_IDLE) && pipe_write && (load_start || (r_count != c_DEPTH));
        w_wr_addr  = load_start ? '0 : r_count[ADDR_WIDTH-1:0];
        w_is_last  = ({1'b0, r_rd_ptr} == (r_count - (ADDR_WIDTH+1)'(1)));
        w_next_ptr = w_is_last ? '0 : (r_rd_ptr + ADDR_WIDTH'(1));
        w_fire     = (r_state == c_PLAY) && !play_stop && !r_done && !r_last && (r_div == '0);
        // On an advance the RAM is pointed at the following sample so its data
        // is ready even when the next update is due one cycle later.
        if (r_state == c_IDLE) begin
            w_rd_addr = '0;
        end else if (w_fire) begin
            w_rd_addr = w_next_ptr;
        end else begin
            w_rd_addr = r_rd_ptr;
        end
    end

    // Sample RAM: one write port from the pipe, one registered read port.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= pipe_data[PRECISION-1:0];
        end
        r_ram_q <= r_mem[w_rd_addr];
    end

    // Load bookkeeping, play control and DAC output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_dac_code   <= '0;
            r_dac_update <= 1'b0;
            r_done       <= 1'b0;
            r_overflow   <= 1'b0;
            r_count      <= '0;
            r_rd_ptr     <= '0;
            r_div        <= '0;
            r_rate       <= '0;
            r_loop       <= 1'b0;
            r_last       <= 1'b0;
        end else begin
            r_dac_update <= 1'b0;
            r_done       <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (load_start) begin
                        r_count    <= {{ADDR_WIDTH{1'b0}}, pipe_write};
                        r_overflow <= 1'b0;
                    end else if (pipe_write) begin
                        if (r_count != c_DEPTH) begin
                            r_count <= r_count + (ADDR_WIDTH+1)'(1);
                        end else begin
                            r_overflow <= 1'b1;
                        end
                    end
                    // A simultaneous stop cancels the start.
                    if (play_start && !play_stop && (r_count != '0)) begin
                        r_state  <= c_PLAY;
                        r_rate   <= rate_div;
                        r_loop   <= loop_en;
                        r_div    <= '0;
                        r_rd_ptr <= '0;
                        r_last   <= 1'b0;
                    end
                end
                c_PLAY: begin
                    if (pipe_write) begin
                        r_overflow <= 1'b1;
                    end
                    // r_done marks the cycle done is visible; leave after it.
                    if (play_stop || r_done) begin
                        r_state <= c_IDLE;
                    end else if (r_div == '0) begin
                        if (r_last) begin
                            r_done <= 1'b1;
                        end else begin
                            r_dac_code   <= r_ram_q;
                            r_dac_update <= 1'b1;
                            r_rd_ptr     <= w_next_ptr;
                            r_div        <= r_rate;
                            r_last       <= w_is_last && !r_loop;
                        end
                    end else begin
                        r_div <= r_div - DIV_WIDTH'(1);
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign dac_code     = r_dac_code;
    assign dac_update   = r_dac_update;
    assign busy         = (r_state == c_PLAY);
    assign done         = r_done;
    assign sample_count = r_count;
    assign overflow     = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_dac_pattern_player.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dac_pattern_player
//  Description : Self-checking bench for dac_pattern_player; a full-size
//                instance and a 4-deep instance share the load inputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dac_pattern_player;

    logic        clk = 1'b0;
    logic        rst, load_start, pipe_write, play_start_b, play_start_s, play_stop, loop_en;
    logic [15:0] pipe_data, rate_div;
    logic [9:0]  code_b, code_s;
    logic        upd_b, upd_s, busy_b, busy_s, done_b, done_s, ovf_b, ovf_s;
    logic [10:0] cnt_b;
    logic [2:0]  cnt_s;

    int errors = 0;
    int checks = 0;

    // Behavioural model: index 0 = full-size instance, 1 = 4-deep instance.
    int          m_depth [2] = '{1024, 4};
    logic [9:0]  m_mem   [2][1024];
    int          m_cnt   [2];
    bit          m_ovf   [2];
    logic [9:0]  m_code  [2];

    always #5 clk = ~clk;

    dac_pattern_player #(.PRECISION(10), .ADDR_WIDTH(10), .DIV_WIDTH(16)) u_big (
        .clk(clk), .rst(rst), .load_start(load_start), .pipe_write(pipe_write),
        .pipe_data(pipe_data), .play_start(play_start_b), .play_stop(play_stop),
        .loop_en(loop_en), .rate_div(rate_div), .dac_code(code_b), .dac_update(upd_b),
        .busy(busy_b), .done(done_b), .sample_count(cnt_b), .overflow(ovf_b));

    dac_pattern_player #(.PRECISION(10), .ADDR_WIDTH(2), .DIV_WIDTH(16)) u_small (
        .clk(clk), .rst(rst), .load_start(load_start), .pipe_write(pipe_write),
        .pipe_data(pipe_data), .play_start(play_start_s), .play_stop(play_stop),
        .loop_en(loop_en), .rate_div(rate_div), .dac_code(code_s), .dac_update(upd_s),
        .busy(busy_s), .done(done_s), .sample_count(cnt_s), .overflow(ovf_s));

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic model_idle_write(input int i, input logic [9:0] d);
        if (m_cnt[i] < m_depth[i]) begin
            m_mem[i][m_cnt[i]] = d;
            m_cnt[i]++;
        end else begin
            m_ovf[i] = 1'b1;
        end
    endtask

    // One load-interface cycle applied to both instances (both idle).
    task automatic do_load(input bit ld, input bit wr, input logic [9:0] d);
        load_start = ld; pipe_write = wr;
        pipe_data  = {6'($urandom), d};
        tick();
        load_start = 1'b0; pipe_write = 1'b0; pipe_data = 16'($urandom);
        for (int i = 0; i < 2; i++) begin
            if (ld) begin m_cnt[i] = 0; m_ovf[i] = 1'b0; end
            if (wr) model_idle_write(i, d);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 2; i++) begin m_cnt[i] = 0; m_ovf[i] = 1'b0; m_code[i] = '0; end
    endtask

    // Starts playback on instance i and checks T cycles of output against the
    // schedule: sample k lands at N+2+k*P, one-shot done at N+2+C*P.
    task automatic run_playback(input int i, input int rate, input bit loop,
                                input int T, input int stop_t, input int wr_t);
        int C = m_cnt[i];
        int P = rate + 1;
        int E = 2 + C * P;
        logic [9:0] exp_code = m_code[i];
        bit e_busy, e_upd, e_done, stopped;
        logic [9:0] o_code;
        bit o_busy, o_upd, o_done;
        if (i == 0) play_start_b = 1'b1; else play_start_s = 1'b1;
        rate_div = 16'(rate); loop_en = loop;
        tick();
        play_start_b = 1'b0; play_start_s = 1'b0;
        rate_div = 16'($urandom); loop_en = 1'($urandom);
        for (int t = 1; t <= T; t++) begin
            if (t == stop_t) play_stop = 1'b1;
            if (t == wr_t) begin
                pipe_write = 1'b1; pipe_data = 16'($urandom);
                m_ovf[i] = 1'b1;
                model_idle_write(1 - i, pipe_data[9:0]);
            end
            stopped = (C == 0) || (stop_t != 0 && t > stop_t);
            if (stopped) begin
                e_busy = 1'b0; e_upd = 1'b0; e_done = 1'b0;
            end else if (loop) begin
                e_busy = 1'b1; e_done = 1'b0;
                e_upd  = (t >= 2) && ((t - 2) % P == 0);
            end else begin
                e_busy = (t <= E); e_done = (t == E);
                e_upd  = (t >= 2) && (t < E) && ((t - 2) % P == 0);
            end
            if (e_upd) exp_code = m_mem[i][((t - 2) / P) % C];
            @(negedge clk);
            o_code = (i == 0) ? code_b : code_s;
            o_busy = (i == 0) ? busy_b : busy_s;
            o_upd  = (i == 0) ? upd_b  : upd_s;
            o_done = (i == 0) ? done_b : done_s;
            checks += 4;
            if (o_busy !== e_busy) begin errors++; $display("FAIL play_busy inst%0d t=%0d got %b exp %b", i, t, o_busy, e_busy); end
            if (o_upd  !== e_upd)  begin errors++; $display("FAIL play_update inst%0d t=%0d got %b exp %b", i, t, o_upd, e_upd); end
            if (o_done !== e_done) begin errors++; $display("FAIL play_done inst%0d t=%0d got %b exp %b", i, t, o_done, e_done); end
            if (o_code !== exp_code) begin errors++; $display("FAIL play_code inst%0d t=%0d got %h exp %h", i, t, o_code, exp_code); end
            tick();
            play_stop = 1'b0; pipe_write = 1'b0;
        end
        m_code[i] = exp_code;
    endtask

    task automatic check_counts(input string tag);
        checks += 4;
        if (int'(cnt_b) !== m_cnt[0]) begin errors++; $display("FAIL %s count_big got %0d exp %0d", tag, cnt_b, m_cnt[0]); end
        if (int'(cnt_s) !== m_cnt[1]) begin errors++; $display("FAIL %s count_small got %0d exp %0d", tag, cnt_s, m_cnt[1]); end
        if (ovf_b !== m_ovf[0]) begin errors++; $display("FAIL %s overflow_big got %b exp %b", tag, ovf_b, m_ovf[0]); end
        if (ovf_s !== m_ovf[1]) begin errors++; $display("FAIL %s overflow_small got %b exp %b", tag, ovf_s, m_ovf[1]); end
    endtask

    task automatic load_words(input logic [9:0] w0, input logic [9:0] w1,
                              input logic [9:0] w2, input logic [9:0] w3);
        do_load(1'b1, 1'b0, '0);
        do_load(1'b0, 1'b1, w0); do_load(1'b0, 1'b1, w1);
        do_load(1'b0, 1'b1, w2); do_load(1'b0, 1'b1, w3);
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks += 8;
        if (code_b !== 10'h000) begin errors++; $display("FAIL reset_code got %h exp 000", code_b); end
        if (upd_b  !== 1'b0)    begin errors++; $display("FAIL reset_update got %b exp 0", upd_b); end
        if (busy_b !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b exp 0", busy_b); end
        if (done_b !== 1'b0)    begin errors++; $display("FAIL reset_done got %b exp 0", done_b); end
        if (code_s !== 10'h000) begin errors++; $display("FAIL reset_code_small got %h exp 000", code_s); end
        if (upd_s  !== 1'b0)    begin errors++; $display("FAIL reset_update_small got %b exp 0", upd_s); end
        if (busy_s !== 1'b0)    begin errors++; $display("FAIL reset_busy_small got %b exp 0", busy_s); end
        if (done_s !== 1'b0)    begin errors++; $display("FAIL reset_done_small got %b exp 0", done_s); end
        tick();
        check_counts("reset");
    endtask

    task automatic test_load_sanity();
        load_words(10'h001, 10'h3FF, 10'h155, 10'h2AA);
        check_counts("load_sanity");
        run_playback(0, 0, 1'b0, 8, 0, 0);
    endtask

    task automatic test_divider_loop();
        run_playback(0, 2, 1'b1, 19, 16, 0);
    endtask

    task automatic test_overflow();
        do_load(1'b1, 1'b0, '0);
        for (int k = 1; k <= 6; k++) do_load(1'b0, 1'b1, 10'(k));
        check_counts("overflow_load");
        run_playback(1, 0, 1'b0, 8, 0, 0);
        do_load(1'b1, 1'b0, '0);
        check_counts("overflow_clear");
    endtask

    task automatic test_empty_and_collisions();
        run_playback(0, 0, 1'b0, 5, 0, 0);
        do_load(1'b1, 1'b1, 10'h007);
        check_counts("load_and_write");
        play_start_b = 1'b1; play_stop = 1'b1; rate_div = '0; loop_en = 1'b0;
        tick();
        play_start_b = 1'b0; play_stop = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks += 2;
            if (busy_b !== 1'b0) begin errors++; $display("FAIL start_stop_busy got %b exp 0", busy_b); end
            if (upd_b  !== 1'b0) begin errors++; $display("FAIL start_stop_update got %b exp 0", upd_b); end
        end
        tick();
        run_playback(0, 1, 1'b0, 6, 0, 0);
    endtask

    task automatic test_write_during_play();
        load_words(10'($urandom), 10'($urandom), 10'($urandom), 10'($urandom));
        run_playback(0, 1, 1'b0, 12, 0, 3);
        check_counts("write_in_play");
    endtask

    task automatic test_reset_mid_play();
        int rate = $urandom_range(0, 2);
        load_words(10'($urandom), 10'($urandom), 10'($urandom), 10'($urandom));
        run_playback(0, rate, 1'b0, 1 + 2 * (rate + 1), 0, 0);
        rst = 1'b1;
        @(negedge clk);
        checks += 2;
        if (upd_b  !== 1'b1)        begin errors++; $display("FAIL third_update got %b exp 1", upd_b); end
        if (code_b !== m_mem[0][2]) begin errors++; $display("FAIL third_code got %h exp %h", code_b, m_mem[0][2]); end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin m_cnt[i] = 0; m_ovf[i] = 1'b0; m_code[i] = '0; end
        checks += 3;
        if (busy_b !== 1'b0)    begin errors++; $display("FAIL rst_play_busy got %b exp 0", busy_b); end
        if (code_b !== 10'h000) begin errors++; $display("FAIL rst_play_code got %h exp 000", code_b); end
        if (cnt_b  !== 11'd0)   begin errors++; $display("FAIL rst_play_count got %0d exp 0", cnt_b); end
        load_words(10'h001, 10'h3FF, 10'h155, 10'h2AA);
        check_counts("reload");
        run_playback(0, 0, 1'b0, 8, 0, 0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            int C    = $urandom_range(1, 12);
            int rate = $urandom_range(0, 3);
            bit loop = 1'($urandom);
            int T;
            do_load(1'b1, 1'b0, '0);
            for (int k = 0; k < C; k++) do_load(1'b0, 1'b1, 10'($urandom));
            check_counts("random_load");
            T = loop ? (2 + 2 * C * (rate + 1) + 3) : (2 + C * (rate + 1) + 2);
            run_playback(0, rate, loop, T, loop ? T - 2 : 0, 0);
        end
    endtask

    initial begin
        rst = 1'b1; load_start = 1'b0; pipe_write = 1'b0; pipe_data = '0;
        play_start_b = 1'b0; play_start_s = 1'b0; play_stop = 1'b0;
        loop_en = 1'b0; rate_div = '0;
        test_reset();
        test_load_sanity();
        test_divider_loop();
        test_overflow();
        test_empty_and_collisions();
        test_write_during_play();
        test_reset_mid_play();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dac_pattern_player.md
Name: dac_pattern_player

Overview:
- Stimulus-side counterpart to the ADC capture path.
- The host streams DAC codes in through a FrontPanel pipe-in, and they are stored in an internal sample RAM.
- On command, the block plays the codes out to the DAC pins at a programmable rate, either one-shot or looped.
- Sits between the okPipeIn/okWireIn endpoints and the DAC output pads; everything runs in the ti_clk domain.

Parameters:
- PRECISION, 10, DAC code width in bits.
- ADDR_WIDTH, 10, sample RAM address width; DEPTH = 2**ADDR_WIDTH words.
- DIV_WIDTH, 16, width of the sample-rate divider.

Ports:
- clk  input  1  system clock (ti_clk); all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- load_start  input  1  pulse: rewind write pointer and clear overflow.
- pipe_write  input  1  pipe-in write strobe; one word per high cycle.
- pipe_data  input  16  pipe-in word; bits [PRECISION-1:0] are used, upper bits ignored.
- play_start  input  1  pulse: begin playback.
- play_stop  input  1  pulse: abort playback.
- loop_en  input  1  level: loop the pattern; latched at play_start.
- rate_div  input  DIV_WIDTH  sample period minus 1, in clk cycles; latched at play_start.
- dac_code  output  PRECISION  code driven to the DAC.
- dac_update  output  1  one-cycle strobe when dac_code changes to a new sample.
- busy  output  1  high while in PLAY.
- done  output  1  one-cycle pulse at the end of a one-shot playback.
- sample_count  output  ADDR_WIDTH+1  number of words currently loaded (0..DEPTH).
- overflow  output  1  sticky: at least one pipe word was dropped.

Behaviour:
- Reset state:
  - state = IDLE; dac_code = 0; dac_update = busy = done = overflow = 0.
  - sample_count = 0; read pointer and divider = 0.
  - RAM contents are not cleared.
- States: IDLE and PLAY.
- Loading, IDLE only:
  - pipe_write with sample_count < DEPTH writes to RAM[sample_count], then sample_count += 1.
  - pipe_write with sample_count == DEPTH drops the word and sets overflow.
  - load_start sets sample_count = 0 and overflow = 0.
  - load_start and pipe_write in the same cycle: the word goes to address 0 and sample_count = 1.
- Loading in PLAY: pipe_write drops the word and sets overflow; load_start is ignored.
- Start, IDLE:
  - play_start with sample_count > 0 moves to PLAY and latches rate_div and loop_en.
  - play_start with sample_count == 0 is ignored; state stays IDLE and no outputs change.
- Playback timing, where N is the play_start cycle and P = latched rate_div + 1:
  - RAM read latency is 1 cycle.
  - The first update (sample 0) lands at cycle N+2: dac_code = RAM[0] and dac_update = 1.
  - Sample k updates at N+2+k*P.
  - rate_div = 0 gives one sample per cycle with dac_update held continuously high.
- busy = 1 from N+1 until the cycle the block returns to IDLE.
- End of pattern, after sample_count-1 has been output:
  - loop_en latched = 1: the next sample is index 0, one period P later, with no gap and no done.
  - loop_en latched = 0: at the cycle the next sample would be due, done = 1 for one cycle, state returns to IDLE and busy = 0.
- dac_code holds its last value in IDLE; it is never forced to 0 except by rst.
- play_stop in PLAY:
  - Next state is IDLE; busy drops the next cycle.
  - No done and no further dac_update; dac_code holds.
  - play_stop is ignored in IDLE.
  - If play_stop and play_start are high in the same cycle, play_stop wins: the state ends in IDLE.
- play_start while already in PLAY is ignored; there is no restart.
- rst while in PLAY returns to IDLE with the reset values above, effective the next cycle.
- rate_div and loop_en changes during PLAY have no effect until the next play_start.
- Divider counter is DIV_WIDTH bits and reloads to rate_div on each update, so it never wraps.

Test Plan:
- Load sanity: rst, load_start, write 4 words 0x001,0x3FF,0x155,0x2AA; play_start with rate_div=0, loop_en=0.
  - sample_count = 4.
  - dac_code = 0x001,0x3FF,0x155,0x2AA on cycles N+2..N+5, with dac_update high on each.
  - done pulses at N+6; busy is low from N+7.
- Divider and loop: same 4 words, rate_div=2, loop_en=1.
  - Updates every 3 cycles; after 0x2AA the next update is 0x001 at N+14.
  - done never pulses; play_stop → busy low next cycle and dac_code holds its value.
- Overflow, with ADDR_WIDTH=2: write 6 words 1..6.
  - sample_count = 4 and overflow = 1; playback outputs 1,2,3,4.
  - A subsequent load_start clears overflow and sets sample_count = 0.
- Empty and collision cases:
  - play_start with sample_count = 0 → busy stays 0 and there is no dac_update.
  - play_start and play_stop high together in IDLE → state stays IDLE.
  - load_start and pipe_write together with data 0x07 → sample_count = 1 and playback outputs 0x07.
- Writes during PLAY: pipe_write mid-playback → overflow = 1, sample_count unchanged, and pattern unaltered.
- Reset mid-play: assert rst at the third update → next cycle busy = 0, dac_code = 0, sample_count = 0.
  - Reloading and replaying then behaves as in the load sanity scenario.
